// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, operand
// forwarding, terminator drain/halt sequencing and stall/flush counters.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal operation; load-use stalls and branch flushes apply
//   DRAIN | terminator seen; fetch frozen while four bubbles drain EX..WB
//   HALT  | pipeline empty; everything frozen until RESET
module hazard_ctrl (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] instrD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        RegWriteE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        BranchTakenE,
  input  logic        terminatorD,
  output logic        stallF,
  output logic        stallD,
  output logic        RFflush,
  output logic        IFflush,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0]  DRAIN_LOAD = 3'd4;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t     state;
  state_t     state_eff;
  logic [2:0] drain_cnt;
  logic       is_load;
  logic       load_use;
  logic       branch_flush;
  logic       lu_stall;
  logic       unused_instr_bits;

  // Only the rs/rt fields of the decode instruction matter for hazards.
  assign unused_instr_bits = ^{instrD[31:26], instrD[15:0]};

  // While RESET is high the outputs already behave as in RUN.
  always_comb begin
    state_eff = state;
    if (RESET) state_eff = RUN;
  end

  assign is_load  = MemtoRegE & ~MemWriteE;
  assign load_use = is_load & RegWriteE & (RtE != 5'd0) &
                    ((RtE == instrD[25:21]) | (RtE == instrD[20:16]));

  // A taken branch squashes the dependent decode instruction, so it overrides load-use.
  assign branch_flush = (state_eff == RUN) & BranchTakenE;
  assign lu_stall     = (state_eff == RUN) & ~BranchTakenE & load_use;

  // Stall / flush / halt outputs decoded from the effective state.
  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    RFflush = 1'b0;
    IFflush = 1'b0;
    halted  = 1'b0;
    case (state_eff)
      RUN: begin
        if (branch_flush) begin
          IFflush = 1'b1;
          RFflush = 1'b1;
        end else if (lu_stall) begin
          stallF  = 1'b1;
          RFflush = 1'b1;
        end
      end
      DRAIN: begin
        stallF  = 1'b1;
        RFflush = 1'b1;
      end
      HALT: begin
        stallF = 1'b1;
        stallD = 1'b1;
        halted = 1'b1;
      end
      default: begin
        stallF = 1'b0;
      end
    endcase
  end

  // Forwarding: MEM result beats WB result; $0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))
      ForwardAE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE))
      ForwardAE = 2'b01;
  end

  // Same selection for the second EX operand.
  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))
      ForwardBE = 2'b10;
    else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE))
      ForwardBE = 2'b01;
  end

  // Sequencer: terminator enters DRAIN, drain counter walks 4..1, then HALT.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= RUN;
      drain_cnt <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (terminatorD && !BranchTakenE) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd1) begin
            state     <= HALT;
            drain_cnt <= 3'd0;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state     <= RUN;
          drain_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge CLOCK) begin
    if (RESET)
      stall_cnt <= 16'd0;
    else if (lu_stall && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + 16'd1;
  end

  // Saturating count of taken-branch flushes.
  always_ff @(posedge CLOCK) begin
    if (RESET)
      flush_cnt <= 16'd0;
    else if (branch_flush && (flush_cnt != CNT_MAX))
      flush_cnt <= flush_cnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] instrD;
  logic [4:0]  RsE, RtE, WriteRegM, WriteRegW;
  logic        MemtoRegE, MemWriteE, RegWriteE, RegWriteM, RegWriteW;
  logic        BranchTakenE, terminatorD;
  logic        stallF, stallD, RFflush, IFflush, halted;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // model state: mode 0=running, 1=draining, 2=halted
  int m_mode = 0;
  int m_drain_done = 0;
  int m_stall = 0;
  int m_flush = 0;

  // model expected outputs
  logic       e_stallF, e_stallD, e_RFflush, e_IFflush, e_halted;
  logic [1:0] e_fa, e_fb;

  always #5 CLOCK = ~CLOCK;

  hazard_ctrl dut (
    .CLOCK(CLOCK), .RESET(RESET), .instrD(instrD), .RsE(RsE), .RtE(RtE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .BranchTakenE(BranchTakenE), .terminatorD(terminatorD),
    .stallF(stallF), .stallD(stallD), .RFflush(RFflush), .IFflush(IFflush),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic bit model_load_use();
    int rt, rs_d, rt_d;
    rt   = int'(RtE);
    rs_d = int'(instrD[25:21]);
    rt_d = int'(instrD[20:16]);
    return MemtoRegE && !MemWriteE && RegWriteE && rt != 0 && (rt == rs_d || rt == rt_d);
  endfunction

  function automatic logic [1:0] model_fwd(input int src);
    if (src != 0 && RegWriteM && int'(WriteRegM) == src) return 2'b10;
    if (src != 0 && RegWriteW && int'(WriteRegW) == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_outputs();
    int mode;
    mode = RESET ? 0 : m_mode;
    e_stallF = 0; e_stallD = 0; e_RFflush = 0; e_IFflush = 0; e_halted = 0;
    if (mode == 0) begin
      if (BranchTakenE) begin e_IFflush = 1; e_RFflush = 1; end
      else if (model_load_use()) begin e_stallF = 1; e_RFflush = 1; end
    end else if (mode == 1) begin
      e_stallF = 1; e_RFflush = 1;
    end else begin
      e_stallF = 1; e_stallD = 1; e_halted = 1;
    end
    e_fa = model_fwd(int'(RsE));
    e_fb = model_fwd(int'(RtE));
  endtask

  task automatic model_edge();
    if (RESET) begin
      m_mode = 0; m_drain_done = 0; m_stall = 0; m_flush = 0;
    end else if (m_mode == 0) begin
      if (BranchTakenE) begin
        if (m_flush < 65535) m_flush++;
      end else if (model_load_use()) begin
        if (m_stall < 65535) m_stall++;
      end
      if (terminatorD && !BranchTakenE) begin
        m_mode = 1; m_drain_done = 0;
      end
    end else if (m_mode == 1) begin
      m_drain_done++;
      if (m_drain_done == 4) m_mode = 2;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_idle();
    instrD = 32'd0; RsE = 5'd0; RtE = 5'd0;
    MemtoRegE = 0; MemWriteE = 0; RegWriteE = 0;
    WriteRegM = 5'd0; WriteRegW = 5'd0; RegWriteM = 0; RegWriteW = 0;
    BranchTakenE = 0; terminatorD = 0;
  endtask

  task automatic do_reset();
    set_idle();
    RESET = 1;
    tick();
    RESET = 0;
    #1;
  endtask

  task automatic set_load_use();
    MemtoRegE = 1; MemWriteE = 0; RegWriteE = 1; RtE = 5'd8;
    instrD = {6'd0, 5'd8, 5'd8, 5'd9, 5'd0, 6'h20};
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stallF !== 1'b0) begin errors++; $display("FAIL reset_stallF got=%b exp=0", stallF); end
    checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL reset_stallD got=%b exp=0", stallD); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt got=%h exp=0", flush_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    checks++; if ({stallF, RFflush, IFflush, stallD} !== 4'b1100) begin errors++; $display("FAIL lu_outputs got=%b exp=1100", {stallF, RFflush, IFflush, stallD}); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL lu_cnt_before got=%h exp=0", stall_cnt); end
    tick();
    // bubble now in EX: no load there any more
    MemtoRegE = 0; RegWriteE = 0;
    #1;
    checks++; if ({stallF, RFflush} !== 2'b00) begin errors++; $display("FAIL lu_one_cycle got=%b exp=00", {stallF, RFflush}); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_after got=%h exp=1", stall_cnt); end
    // $0 never stalls
    set_load_use(); RtE = 5'd0; instrD = 32'd0;
    #1;
    checks++; if (stallF !== 1'b0) begin errors++; $display("FAIL lu_reg0 got=%b exp=0", stallF); end
    // a store is not a load
    set_load_use(); MemWriteE = 1;
    #1;
    checks++; if (stallF !== 1'b0) begin errors++; $display("FAIL lu_store got=%b exp=0", stallF); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_use();
    BranchTakenE = 1;
    #1;
    checks++; if ({IFflush, RFflush, stallF} !== 3'b110) begin errors++; $display("FAIL br_outputs got=%b exp=110", {IFflush, RFflush, stallF}); end
    tick();
    set_idle();
    #1;
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got=%h exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL br_stall_cnt got=%h exp=0", stall_cnt); end
  endtask

  task automatic test_forward();
    set_idle();
    RegWriteM = 1; WriteRegM = 5'd5; RegWriteW = 1; WriteRegW = 5'd5; RsE = 5'd5; RtE = 5'd5;
    #1;
    checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_mem got=%b exp=10", ForwardAE); end
    checks++; if (ForwardBE !== 2'b10) begin errors++; $display("FAIL fwdB_mem got=%b exp=10", ForwardBE); end
    WriteRegM = 5'd0;
    #1;
    checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_wb got=%b exp=01", ForwardAE); end
    RsE = 5'd0; WriteRegW = 5'd0;
    #1;
    checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_reg0 got=%b exp=00", ForwardAE); end
    RtE = 5'd7; WriteRegW = 5'd7; RegWriteW = 0;
    #1;
    checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdB_nowe got=%b exp=00", ForwardBE); end
  endtask

  task automatic test_drain_halt();
    do_reset();
    // terminator on the wrong path is ignored
    terminatorD = 1; BranchTakenE = 1;
    tick();
    set_idle();
    #1;
    checks++; if ({stallF, halted} !== 2'b00) begin errors++; $display("FAIL term_wrong_path got=%b exp=00", {stallF, halted}); end
    terminatorD = 1;
    tick();
    set_idle();
    for (int i = 0; i < 4; i++) begin
      // branch and load-use are ignored during drain
      set_load_use(); BranchTakenE = 1;
      #1;
      checks++; if ({stallF, RFflush, IFflush, stallD, halted} !== 5'b11000) begin errors++; $display("FAIL drain_cycle%0d got=%b exp=11000", i, {stallF, RFflush, IFflush, stallD, halted}); end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if ({stallF, stallD, halted, RFflush, IFflush} !== 5'b11100) begin errors++; $display("FAIL halt_cycle%0d got=%b exp=11100", i, {stallF, stallD, halted, RFflush, IFflush}); end
      tick();
    end
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin errors++; $display("FAIL drain_counters got=%h/%h exp=0001/0000", flush_cnt, stall_cnt); end
    // outputs behave as RUN while RESET is high
    set_idle(); BranchTakenE = 0; set_load_use(); RESET = 1;
    #1;
    checks++; if ({stallF, stallD, halted, RFflush} !== 4'b1001) begin errors++; $display("FAIL reset_in_halt got=%b exp=1001", {stallF, stallD, halted, RFflush}); end
    tick();
    RESET = 0; set_idle();
    #1;
    checks++; if ({stallF, stallD, halted, stall_cnt} !== {3'b000, 16'd0}) begin errors++; $display("FAIL after_reset got=%b cnt=%h exp=000 cnt=0", {stallF, stallD, halted}, stall_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      RESET        = ($urandom_range(0, 59) == 0);
      terminatorD  = ($urandom_range(0, 39) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      MemtoRegE    = 1'($urandom_range(0, 1));
      MemWriteE    = ($urandom_range(0, 3) == 0);
      RegWriteE    = 1'($urandom_range(0, 1));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      RsE          = 5'($urandom_range(0, 3));
      RtE          = 5'($urandom_range(0, 3));
      WriteRegM    = 5'($urandom_range(0, 3));
      WriteRegW    = 5'($urandom_range(0, 3));
      instrD       = $urandom;
      instrD[25:21] = 5'($urandom_range(0, 3));
      instrD[20:16] = 5'($urandom_range(0, 3));
      #1;
      model_outputs();
      checks++; if (stallF !== e_stallF) begin errors++; $display("FAIL rnd_stallF n=%0d got=%b exp=%b", n, stallF, e_stallF); end
      checks++; if (stallD !== e_stallD) begin errors++; $display("FAIL rnd_stallD n=%0d got=%b exp=%b", n, stallD, e_stallD); end
      checks++; if (RFflush !== e_RFflush) begin errors++; $display("FAIL rnd_RFflush n=%0d got=%b exp=%b", n, RFflush, e_RFflush); end
      checks++; if (IFflush !== e_IFflush) begin errors++; $display("FAIL rnd_IFflush n=%0d got=%b exp=%b", n, IFflush, e_IFflush); end
      checks++; if (halted !== e_halted) begin errors++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, halted, e_halted); end
      checks++; if (ForwardAE !== e_fa) begin errors++; $display("FAIL rnd_ForwardAE n=%0d got=%b exp=%b", n, ForwardAE, e_fa); end
      checks++; if (ForwardBE !== e_fb) begin errors++; $display("FAIL rnd_ForwardBE n=%0d got=%b exp=%b", n, ForwardBE, e_fb); end
      checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_stall); end
      checks++; if (flush_cnt !== 16'(m_flush)) begin errors++; $display("FAIL rnd_flush_cnt n=%0d got=%0d exp=%0d", n, flush_cnt, m_flush); end
      tick();
    end
    RESET = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use();
    repeat (65534) tick();
    checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=ffff", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL sat_model got=%h exp=%h", stall_cnt, 16'(m_stall)); end
  endtask

  initial begin
    set_idle();
    RESET = 1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_forward();
    test_drain_halt();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 CLOCK  in  1  single clock; all state updates on rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset.
REQ-003 instrD  in  32  instruction currently presented to the decode/register-file stage.
REQ-004 RsE, RtE  in  5 each  source register addresses latched into EX.
REQ-005 MemtoRegE, MemWriteE, RegWriteE  in  1 each  EX-stage control; load = MemtoRegE & ~MemWriteE.
REQ-006 WriteRegM, WriteRegW  in  5 each; RegWriteM, RegWriteW  in  1 each  MEM/WB destination and write enable.
REQ-007 BranchTakenE  in  1  EX resolved a taken beq/bne or a j/jal/jr this cycle.
REQ-008 terminatorD  in  1  decode stage has latched the 32'hffffffff terminator.
REQ-009 stallF  out  1  hold PC and the fetch/decode instruction register.
REQ-010 stallD  out  1  drives the decode-stage stall input.
REQ-011 RFflush  out  1  inject a bubble into ID/EX (decode produces no-op, ALUControl 5'b10010).
REQ-012 IFflush  out  1  discard the instruction currently in fetch/decode.
REQ-013 ForwardAE, ForwardBE  out  2 each  EX operand select: 00 register file, 10 from MEM, 01 from WB.
REQ-014 halted  out  1  pipeline fully drained after the terminator.
REQ-015 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-016 FSM states SHALL be RUN, DRAIN, HALT; RESET forces RUN.
REQ-017 Load-use SHALL be detected in RUN when load & RegWriteE & RtE!=0 & (RtE==instrD[25:21] | RtE==instrD[20:16]).
REQ-018 Load-use SHALL assert stallF=1 and RFflush=1 combinationally in the same cycle, with stallD=0; this creates exactly one bubble.
REQ-019 BranchTakenE in RUN SHALL assert IFflush=1 and RFflush=1 for that cycle, with stallF=0.
REQ-020 When BranchTakenE and load-use coincide, the branch SHALL win: load-use is suppressed and stallF=0.
REQ-021 In RUN, terminatorD=1 with BranchTakenE=0 SHALL move to DRAIN on the next edge; when BranchTakenE=1, the terminator is treated as wrong-path and ignored.
REQ-022 DRAIN SHALL hold stallF=1 and RFflush=1, with stallD=0.
REQ-023 DRAIN SHALL use a 3-bit drain counter loaded with 4 on entry and decremented each cycle; the FSM moves to HALT on the edge where the counter equals 1.
REQ-024 HALT SHALL assert stallF=1, stallD=1, halted=1 and RFflush=0; HALT is exited only by RESET.
REQ-025 In DRAIN and HALT, BranchTakenE and load-use SHALL be ignored.
REQ-026 ForwardAE SHALL be purely combinational in every state:
- 10 when RegWriteM & WriteRegM!=0 & WriteRegM==RsE;
- else 01 when RegWriteW & WriteRegW!=0 & WriteRegW==RsE;
- else 00.
ForwardBE SHALL be identical, using RtE; MEM priority over WB.
REQ-027 stall_cnt SHALL increment by 1 on each edge where load-use stallF was asserted in RUN, saturating at 16'hFFFF.
REQ-028 flush_cnt SHALL increment by 1 on each edge where a branch IFflush was asserted, saturating at 16'hFFFF.
REQ-029 Register $0 SHALL never cause a stall or a forward.

Reset
REQ-030 On RESET=1 at an edge: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0.
REQ-031 Combinational outputs SHALL reflect RUN with the current inputs during the cycle RESET is high.
REQ-032 RESET asserted in DRAIN or HALT SHALL return to RUN at that edge; the counters clear and no stall persists.

Verification
REQ-033 lw $8 in EX (RtE=8), instrD = add $9,$8,$8 -> stallF=1, RFflush=1, IFflush=0 for exactly 1 cycle; stall_cnt 0->1.
REQ-034 BranchTakenE=1 with a simultaneous load-use match -> IFflush=1, RFflush=1, stallF=0; flush_cnt +1, stall_cnt unchanged.
REQ-035 RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsE=5 -> ForwardAE=10; same case with WriteRegM=0 -> ForwardAE=01; RsE=0 -> 00.
REQ-036 terminatorD=1 in RUN -> DRAIN for 4 cycles with stallF=1, then halted=1 and stallD=1 held indefinitely; RESET then gives RUN with halted=0.
REQ-037 Force stall_cnt to 16'hFFFF via repeated load-use, then apply one more load-use -> stall_cnt stays at 16'hFFFF.
